// File: rtl/timer_multi_pkg.sv
// Shared definitions for the timer_multi machine timer.
// Contents:
//   - register word indices, taken from address bits [6:2]
//   - bit positions of the fields inside the CTRL word
//   - merge_bytes(): applies a 4-bit byte-lane write mask to a 32-bit register word
package timer_multi_pkg;

  localparam logic [4:0] TIMER_MTIMEL   = 5'd0;
  localparam logic [4:0] TIMER_MTIMEH   = 5'd1;
  localparam logic [4:0] TIMER_CTRL     = 5'd2;
  localparam logic [4:0] TIMER_STATUS   = 5'd3;
  // Compare channel i occupies word indices CMP_BASE+2i (low) and CMP_BASE+2i+1 (high).
  localparam logic [4:0] TIMER_CMP_BASE = 5'd4;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IE_LSB       = 8;
  localparam int CTRL_PRESCALE_LSB = 16;

  // Lanes with a 1 in the mask take the new byte. Lanes with a 0 keep the old byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = mask[b] ? new_value[8*b +: 8] : old_value[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Data bus interface used by timer_multi.
// Signals:
//   address_in      byte address driven by the bus master
//   sel_in          peripheral select
//   read_in         read strobe
//   read_value_out  read data returned by the timer
//   write_mask_in   byte enables
//   write_value_in  write data
// Modports:
//   master  the core or interconnect side
//   slave   the timer side
// The _in/_out suffixes describe direction as seen from the timer.
interface timer_multi_if;
  import timer_multi_pkg::*;

  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out
  );

endinterface

// File: rtl/timer_multi_prescaler.sv
// Prescaler for the timer_multi mtime counter.
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   enable  count enable. The counter holds its value while this is low.
//   clear   restarts the period from zero (driven by a CTRL write)
//   reload  terminal count. The tick period is reload+1 clock cycles.
//   tick    one-cycle pulse when the count reaches reload while enabled
module timer_multi_prescaler
  import timer_multi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] reload,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  // A clear restarts the period, so no tick is issued in the clear cycle.
  // Otherwise a CTRL write could produce a tick early.
  assign tick = enable && !clear && (count == reload);

  // The counter runs from 0 to reload and then wraps to 0.
  // It holds while enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == reload) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_multi.sv
// Memory-mapped machine timer.
// Features:
//   - free-running 64-bit mtime, advanced by a programmable prescaler
//   - NUM_CMP 64-bit compare channels, each with a sticky pending bit and a registered irq
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset. It overrides any bus write in the same cycle.
//   bus      data bus slave (timer_multi_if.slave)
//   irq_out  per-channel interrupt. It equals pending & enable, registered one cycle.
// Register map (word index):
//   0 MTIMEL, 1 MTIMEH, 2 CTRL, 3 STATUS (write 1 to clear), 4+2i CMPL_i, 5+2i CMPH_i
// Unmapped reads return 0. Unmapped writes are ignored.
// NUM_CMP must be 1..8 and PRESCALE_WIDTH must be 1..16 so that the CTRL fields fit.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NUM_CMP        = 2,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  timer_multi_if.slave       bus,
  output logic [NUM_CMP-1:0] irq_out
);

  logic [63:0]                   mtime;
  logic                          ctrl_en;
  logic [NUM_CMP-1:0]            ctrl_ie;
  logic [PRESCALE_WIDTH-1:0]     ctrl_prescale;
  logic [31:0]                   ctrl_word;
  logic [31:0]                   ctrl_wr_value;
  logic [NUM_CMP-1:0]            status;
  logic [NUM_CMP-1:0]            status_next;
  logic [NUM_CMP-1:0]            match;
  logic [NUM_CMP-1:0]            w1c;
  logic [NUM_CMP-1:0][63:0]      cmp_all;
  logic                          tick;
  logic [4:0]                    word_idx;
  logic                          wr_en;
  logic                          wr_ctrl;
  logic                          wr_mtimel;
  logic                          wr_mtimeh;
  logic [31:0]                   read_data;
  logic                          unused_ok;

  assign word_idx  = bus.address_in[6:2];
  assign wr_en     = bus.sel_in && (|bus.write_mask_in);
  assign wr_ctrl   = wr_en && (word_idx == TIMER_CTRL);
  assign wr_mtimel = wr_en && (word_idx == TIMER_MTIMEL);
  assign wr_mtimeh = wr_en && (word_idx == TIMER_MTIMEH);

  // Address bits outside the word index do not take part in decoding.
  // The CTRL bits that are merged but not stored are reserved.
  assign unused_ok = ^{bus.address_in[31:7], bus.address_in[1:0], ctrl_wr_value};

  // Build the architectural CTRL word from its stored fields.
  // Reserved bits read as 0.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = ctrl_en;
    ctrl_word[CTRL_IE_LSB +: NUM_CMP] = ctrl_ie;
    ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = ctrl_prescale;
  end

  assign ctrl_wr_value = merge_bytes(ctrl_word, bus.write_value_in, bus.write_mask_in);

  timer_multi_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (ctrl_en),
    .clear  (wr_ctrl),
    .reload (ctrl_prescale),
    .tick   (tick)
  );

  // CTRL register fields. Byte-masked writes only affect the lanes that are written.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en       <= 1'b0;
      ctrl_ie       <= '0;
      ctrl_prescale <= '0;
    end else if (wr_ctrl) begin
      ctrl_en       <= ctrl_wr_value[CTRL_EN_BIT];
      ctrl_ie       <= ctrl_wr_value[CTRL_IE_LSB +: NUM_CMP];
      ctrl_prescale <= ctrl_wr_value[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
    end
  end

  // mtime counter.
  // A software write to either half takes priority over a tick in the same cycle.
  // It suppresses the increment and leaves the other half alone (no carry).
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= '0;
    end else if (wr_mtimel) begin
      mtime[31:0] <= merge_bytes(mtime[31:0], bus.write_value_in, bus.write_mask_in);
    end else if (wr_mtimeh) begin
      mtime[63:32] <= merge_bytes(mtime[63:32], bus.write_value_in, bus.write_mask_in);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    localparam logic [4:0] LO_IDX = TIMER_CMP_BASE + 5'(2 * i);
    localparam logic [4:0] HI_IDX = TIMER_CMP_BASE + 5'(2 * i + 1);

    logic [63:0] cmp_value;

    // Each compare value is updated one byte-masked 32-bit half at a time.
    // It resets to all ones so that it cannot match.
    always_ff @(posedge clk) begin
      if (reset) begin
        cmp_value <= '1;
      end else if (wr_en && (word_idx == LO_IDX)) begin
        cmp_value[31:0] <= merge_bytes(cmp_value[31:0], bus.write_value_in, bus.write_mask_in);
      end else if (wr_en && (word_idx == HI_IDX)) begin
        cmp_value[63:32] <= merge_bytes(cmp_value[63:32], bus.write_value_in, bus.write_mask_in);
      end
    end

    assign cmp_all[i] = cmp_value;
    assign match[i]   = (mtime >= cmp_value);
    // STATUS bits all sit in byte lane 0, because NUM_CMP is at most 8.
    assign w1c[i]     = wr_en && (word_idx == TIMER_STATUS) &&
                        bus.write_mask_in[0] && bus.write_value_in[i];
  end

  // A match sets the pending bit in the same cycle as a write-1-to-clear of that bit.
  // The set wins.
  assign status_next = match | (status & ~w1c);

  // Pending bits, and the interrupt lines registered from their next-state value.
  always_ff @(posedge clk) begin
    if (reset) begin
      status  <= '0;
      irq_out <= '0;
    end else begin
      status  <= status_next;
      irq_out <= status_next & ctrl_ie;
    end
  end

  // Read data is built combinationally from the current register state.
  // A read in a write cycle therefore returns the old value.
  always_comb begin
    read_data = '0;
    if (bus.sel_in && bus.read_in) begin
      case (word_idx)
        TIMER_MTIMEL: read_data = mtime[31:0];
        TIMER_MTIMEH: read_data = mtime[63:32];
        TIMER_CTRL:   read_data = ctrl_word;
        TIMER_STATUS: read_data[NUM_CMP-1:0] = status;
        default: begin
          for (int i = 0; i < NUM_CMP; i++) begin
            if (word_idx == TIMER_CMP_BASE + 5'(2 * i)) begin
              read_data = cmp_all[i][31:0];
            end
            if (word_idx == TIMER_CMP_BASE + 5'(2 * i + 1)) begin
              read_data = cmp_all[i][63:32];
            end
          end
        end
      endcase
    end
  end

  assign bus.read_value_out = read_data;

endmodule
